// File: rtl/fifo_pkg.sv
// Shared types and helpers for the bus_fifo block.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_fifo.sv
// Synchronous FIFO with level flags, sticky overflow/underflow and a
// selectable standard (1-cycle latency) or first-word-fall-through read port.
module bus_fifo
    import fifo_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter int         DEPTH     = 16,
    parameter int         AF_THRESH = DEPTH - 4,
    parameter int         AE_THRESH = 4,
    parameter fifo_mode_e MODE      = FIFO_STD,
    localparam int        AW        = $clog2(DEPTH),
    localparam int        CW        = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enq,
    input  logic             deq,
    input  logic             flush,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    if (WIDTH < 1) begin : g_bad_width
        $error("bus_fifo: WIDTH must be >= 1");
    end
    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("bus_fifo: DEPTH must be a power of two >= 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1) begin : g_bad_af
        $error("bus_fifo: AF_THRESH out of range 1..DEPTH-1");
    end
    if (AE_THRESH < 1 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("bus_fifo: AE_THRESH out of range 1..DEPTH-1");
    end

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] rd_data;
    logic             wr_ok, rd_ok;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    assign wr_ok = enq && !full;
    assign rd_ok = deq && !empty;

    // Pointers are exactly AW bits so they wrap DEPTH-1 -> 0 on their own.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (enq && full)  overflow  <= 1'b1;
            if (deq && empty) underflow <= 1'b1;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok && rstn && !flush),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        // Masking when empty keeps the undefined storage off the bus.
        assign data_out = empty ? '0 : rd_data;
        assign valid    = !empty;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;
        logic             vld_q;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                dout_q <= '0;
                vld_q  <= 1'b0;
            end else if (flush) begin
                vld_q  <= 1'b0;
            end else begin
                vld_q <= rd_ok;
                if (rd_ok) dout_q <= rd_data;
            end
        end

        assign data_out = dout_q;
        assign valid    = vld_q;
    end

endmodule
